// File: rtl/fcounter_pkg.sv
// Shared types and helpers for the fcounter measurement scheduler.
package fcounter_pkg;

    localparam int FCOUNTER_SCHED_CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_START,
        S_WAIT_LO,
        S_WAIT_HI,
        S_STORE,
        S_NEXT
    } sched_state_e;

    typedef struct packed {
        logic       found;
        logic [3:0] ch;
    } chan_sel_t;

    // Lowest set bit strictly above cur; found=0 when none remains.
    function automatic chan_sel_t next_channel(input logic [15:0] mask, input logic [3:0] cur);
        chan_sel_t r;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                r.found = 1'b1;
                r.ch    = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fcounter_sched_bank.sv
// Per-channel result register file: synchronous write, async read, valid flags cleared by mask.
module fcounter_sched_bank
    import fcounter_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [$clog2(M)-1:0] wr_addr_i,
    input  logic [N-1:0]         wr_data_i,
    input  logic                 clr_en_i,
    input  logic [M-1:0]         clr_mask_i,
    input  logic [$clog2(M)-1:0] rd_addr_i,
    output logic [N-1:0]         rd_data_o,
    output logic [M-1:0]         valid_o
);

    logic [N-1:0] bank_q [M];
    logic [M-1:0] valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < M; i++) begin
                bank_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            if (clr_en_i) begin
                valid_q <= valid_q & ~clr_mask_i;
            end
            if (wr_en_i) begin
                bank_q[wr_addr_i]  <= wr_data_i;
                valid_q[wr_addr_i] <= 1'b1;
            end
        end
    end

    // Addresses beyond M (non-power-of-two M) read as zero.
    assign rd_data_o = (int'(rd_addr_i) < M) ? bank_q[rd_addr_i] : '0;
    assign valid_o   = valid_q;

endmodule

// File: rtl/fcounter_sched.sv
// Sweeps enabled channels through one shared fcounter via the ms_clk mux.
// Optional wait-state timeout: define FCOUNTER_SCHED_TIMEOUT_EN.
module fcounter_sched
    import fcounter_pkg::*;
#(
    parameter int N       = 8,
    parameter int M       = 4,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 continuous_i,
    input  logic [M-1:0]         ch_mask_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [$clog2(M)-1:0] ms_sel_o,
    output logic                 fcounter_ce_o,
    output logic                 fcounter_som_o,
    input  logic                 fcounter_eom_i,
    input  logic                 fcounter_rdy_i,
    input  logic [N-1:0]         fcounter_adata_i,
    input  logic [$clog2(M)-1:0] rd_addr_i,
    output logic [N-1:0]         rd_data_o,
    output logic [M-1:0]         valid_o
`ifdef FCOUNTER_SCHED_TIMEOUT_EN
    ,
    output logic [M-1:0]         timeout_err_o
`endif
);

    // state     | meaning
    // IDLE      | wait for start | SELECT: mux settle, then wait rdy | START: som pulse
    // WAIT_LO   | wait eom fall  | WAIT_HI: wait eom rise | STORE: bank write | NEXT: advance
    localparam int SEL_W = $clog2(M);
    localparam int SET_W = $clog2(SETTLE + 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE - 1);

    sched_state_e     state_q;
    logic [M-1:0]     mask_q;
    logic [SEL_W-1:0] ms_sel_q;
    logic [SET_W-1:0] settle_q;
    logic             busy_q;
    logic             done_q;
    logic             ce_q;
    logic             som_q;

    chan_sel_t        first_c;
    chan_sel_t        nxt_c;
    logic [SEL_W-1:0] first_sel_d;
    logic             wr_en;
    logic             clr_en;

`ifdef FCOUNTER_SCHED_TIMEOUT_EN
    localparam logic [FCOUNTER_SCHED_CNT_W-1:0] WAIT_LOAD = FCOUNTER_SCHED_CNT_W'(TIMEOUT - 1);
    logic [FCOUNTER_SCHED_CNT_W-1:0] wait_q;
    logic [M-1:0]                    terr_q;
`endif

    assign first_c     = next_channel(16'(ch_mask_i), 4'd0);
    assign first_sel_d = ch_mask_i[0] ? '0 : SEL_W'(first_c.ch);
    assign nxt_c       = next_channel(16'(mask_q), 4'(ms_sel_q));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            mask_q   <= '0;
            ms_sel_q <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ce_q     <= 1'b0;
            som_q    <= 1'b0;
`ifdef FCOUNTER_SCHED_TIMEOUT_EN
            wait_q   <= '0;
            terr_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            som_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mask_q   <= ch_mask_i;
                        ms_sel_q <= first_sel_d;
                        settle_q <= SETTLE_LOAD;
`ifdef FCOUNTER_SCHED_TIMEOUT_EN
                        terr_q   <= terr_q & ~ch_mask_i;
`endif
                        if (|ch_mask_i) begin
                            state_q <= S_SELECT;
                            busy_q  <= 1'b1;
                        end else begin
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_SELECT: begin
                    if (settle_q != '0) begin
                        settle_q <= settle_q - 1'b1;
                    end else if (fcounter_rdy_i) begin
                        state_q <= S_START;
                        ce_q    <= 1'b1;
                        som_q   <= 1'b1;
                    end
                end
                S_START: begin
                    state_q <= S_WAIT_LO;
`ifdef FCOUNTER_SCHED_TIMEOUT_EN
                    wait_q  <= WAIT_LOAD;
`endif
                end
                S_WAIT_LO: begin
                    if (!fcounter_eom_i) begin
                        state_q <= S_WAIT_HI;
`ifdef FCOUNTER_SCHED_TIMEOUT_EN
                        wait_q  <= WAIT_LOAD;
                    end else if (wait_q == '0) begin
                        terr_q[ms_sel_q] <= 1'b1;
                        ce_q             <= 1'b0;
                        done_q           <= !nxt_c.found;
                        state_q          <= S_NEXT;
                    end else begin
                        wait_q <= wait_q - 1'b1;
`endif
                    end
                end
                S_WAIT_HI: begin
                    if (fcounter_eom_i) begin
                        state_q <= S_STORE;
`ifdef FCOUNTER_SCHED_TIMEOUT_EN
                    end else if (wait_q == '0) begin
                        terr_q[ms_sel_q] <= 1'b1;
                        ce_q             <= 1'b0;
                        done_q           <= !nxt_c.found;
                        state_q          <= S_NEXT;
                    end else begin
                        wait_q <= wait_q - 1'b1;
`endif
                    end
                end
                S_STORE: begin
                    ce_q    <= 1'b0;
                    done_q  <= !nxt_c.found;
                    state_q <= S_NEXT;
                end
                S_NEXT: begin
                    if (nxt_c.found) begin
                        ms_sel_q <= SEL_W'(nxt_c.ch);
                        settle_q <= SETTLE_LOAD;
                        state_q  <= S_SELECT;
                    end else if (continuous_i && (|ch_mask_i)) begin
                        mask_q   <= ch_mask_i;
                        ms_sel_q <= first_sel_d;
                        settle_q <= SETTLE_LOAD;
                        state_q  <= S_SELECT;
`ifdef FCOUNTER_SCHED_TIMEOUT_EN
                        terr_q   <= terr_q & ~ch_mask_i;
`endif
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    ce_q    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wr_en  = (state_q == S_STORE);
    assign clr_en = ((state_q == S_IDLE) && start_i) ||
                    ((state_q == S_NEXT) && !nxt_c.found && continuous_i);

    fcounter_sched_bank #(
        .N (N),
        .M (M)
    ) u_bank (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_en_i    (wr_en),
        .wr_addr_i  (ms_sel_q),
        .wr_data_i  (fcounter_adata_i),
        .clr_en_i   (clr_en),
        .clr_mask_i (ch_mask_i),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .valid_o    (valid_o)
    );

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign ms_sel_o       = ms_sel_q;
    assign fcounter_ce_o  = ce_q;
    assign fcounter_som_o = som_q;
`ifdef FCOUNTER_SCHED_TIMEOUT_EN
    assign timeout_err_o  = terr_q;
`endif

endmodule

// File: tb/tb_fcounter_sched.sv
// Scoreboard bench for fcounter_sched with a behavioural fcounter model.
module tb_fcounter_sched;

    localparam int N = 8;
    localparam int M = 4;
    localparam int SETTLE = 4;
    localparam int TIMEOUT = 20;

    typedef struct {
        int         ch;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       continuous = 1'b0;
    logic [3:0] ch_mask = '0;
    logic       busy, done, ce, som;
    logic [1:0] ms_sel;
    logic       eom = 1'b1;
    logic       rdy = 1'b1;
    logic [7:0] adata = '0;
    logic [1:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic [3:0] valid;
`ifdef FCOUNTER_SCHED_TIMEOUT_EN
    logic [3:0] terr;
`endif

    int         n_chk = 0;
    int         n_fail = 0;
    int         done_cnt = 0;
    exp_t       exp_q[$];
    logic [1:0] som_q[$];
    logic [7:0] meas_val [4];
    int         hang_ch = -1;
    logic [3:0] prev_valid = '0;

    always #5 clk = ~clk;

    fcounter_sched #(
        .N       (N),
        .M       (M),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .continuous_i     (continuous),
        .ch_mask_i        (ch_mask),
        .busy_o           (busy),
        .done_o           (done),
        .ms_sel_o         (ms_sel),
        .fcounter_ce_o    (ce),
        .fcounter_som_o   (som),
        .fcounter_eom_i   (eom),
        .fcounter_rdy_i   (rdy),
        .fcounter_adata_i (adata),
        .rd_addr_i        (rd_addr),
        .rd_data_o        (rd_data),
        .valid_o          (valid)
`ifdef FCOUNTER_SCHED_TIMEOUT_EN
        ,
        .timeout_err_o    (terr)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0: return busy;
            1: return ce;
            2: return valid[3];
            3: return eom;
`ifdef FCOUNTER_SCHED_TIMEOUT_EN
            4: return terr[1];
`endif
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input string name, input int w, input logic val, input int max_cyc);
        int n = 0;
        while ((sig(w) !== val) && (n < max_cyc)) begin
            @(negedge clk);
            n++;
        end
        chk({"wait ", name}, 32'(sig(w)), 32'(val));
    endtask

    // fcounter model: eom falls 2 cycles after som, rises 3 cycles later with the result.
    always begin
        @(posedge clk);
        #1;
        if (som) begin
            automatic int  ch   = int'(ms_sel);
            automatic bit  hang = (ch == hang_ch);
            repeat (2) @(posedge clk);
            #1 eom = 1'b0;
            if (hang) begin
                automatic int k = 0;
                do begin
                    @(posedge clk);
                    #1;
                    k++;
                end while (ce && (k < 200));
                eom = 1'b1;
            end else begin
                repeat (3) @(posedge clk);
                #1;
                adata = meas_val[ch];
                eom   = 1'b1;
            end
        end
    end

    // Monitor: pops one expected result for every newly set valid bit.
    always @(negedge clk) begin
        logic [3:0] nb;
        exp_t       e;
        if (rst) begin
            prev_valid = '0;
        end else begin
            if (done) done_cnt++;
            if (som) som_q.push_back(ms_sel);
            nb = valid & ~prev_valid;
            prev_valid = valid;
            for (int c = 0; c < 4; c++) begin
                if (nb[c]) begin
                    rd_addr = 2'(c);
                    #1;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL result ch%0d: unexpected, got data 0x%0h", c, rd_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("result ch%0d channel", c), 32'(c), 32'(e.ch));
                        chk($sformatf("result ch%0d data", c), 32'(rd_data), 32'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        int d0;
        for (int i = 0; i < 4; i++) meas_val[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset ce", 32'(ce), 0);
        chk("reset som", 32'(som), 0);
        chk("reset ms_sel", 32'(ms_sel), 0);
        chk("reset valid", 32'(valid), 0);
        chk("reset rd_data", 32'(rd_data), 0);
        rst = 1'b0;
        @(negedge clk);

        // single-shot sweep over ch0 and ch2
        meas_val[0] = 8'h2A;
        meas_val[2] = 8'h91;
        exp_q.push_back('{0, 8'h2A});
        exp_q.push_back('{2, 8'h91});
        som_q.delete();
        done_cnt = 0;
        ch_mask = 4'b0101;
        start = 1'b1;
        for (int i = 1; i <= SETTLE + 1; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 1) chk("t1 busy in select", 32'(busy), 1);
            if (i == SETTLE) chk("t1 no som before settle", 32'(som), 0);
            if (i == SETTLE + 1) begin
                chk("t1 som at settle+1", 32'(som), 1);
                chk("t1 ce at start", 32'(ce), 1);
                chk("t1 ms_sel first", 32'(ms_sel), 0);
            end
        end
        wait_for("t1 idle", 0, 1'b0, 300);
        chk("t1 som count", 32'(som_q.size()), 2);
        if (som_q.size() == 2) begin
            chk("t1 som sel 0", 32'(som_q[0]), 0);
            chk("t1 som sel 1", 32'(som_q[1]), 2);
        end
        chk("t1 done count", 32'(done_cnt), 1);
        chk("t1 valid", 32'(valid), 32'h5);
        chk("t1 scoreboard empty", 32'(exp_q.size()), 0);

        // zero mask
        som_q.delete();
        done_cnt = 0;
        ch_mask = 4'b0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t2 done cycle 1", 32'(done), 1);
        chk("t2 busy", 32'(busy), 0);
        @(negedge clk);
        chk("t2 done single", 32'(done), 0);
        chk("t2 busy stays 0", 32'(busy), 0);
        chk("t2 no som", 32'(som_q.size()), 0);

        // continuous sweeps on ch3
        som_q.delete();
        done_cnt = 0;
        meas_val[3] = 8'h10;
        exp_q.push_back('{3, 8'h10});
        continuous = 1'b1;
        ch_mask = 4'b1000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_for("t3 first valid", 2, 1'b1, 300);
        meas_val[3] = 8'h11;
        exp_q.push_back('{3, 8'h11});
        wait_for("t3 valid clear", 2, 1'b0, 50);
        wait_for("t3 second valid", 2, 1'b1, 300);
        meas_val[3] = 8'h12;
        exp_q.push_back('{3, 8'h12});
        wait_for("t3 third start", 1, 1'b1, 50);
        continuous = 1'b0;
        d0 = done_cnt;
        wait_for("t3 idle", 0, 1'b0, 300);
        chk("t3 one more done", 32'(done_cnt - d0), 1);
        chk("t3 sweeps", 32'(som_q.size()), 3);
        chk("t3 valid ch3", 32'(valid[3]), 1);
        chk("t3 scoreboard empty", 32'(exp_q.size()), 0);

        // rdy low holds SELECT
        som_q.delete();
        meas_val[1] = 8'h5C;
        exp_q.push_back('{1, 8'h5C});
        rdy = 1'b0;
        ch_mask = 4'b0010;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (SETTLE + 3) @(negedge clk);
        chk("t4 no som while not ready", 32'(som_q.size()), 0);
        chk("t4 busy holding", 32'(busy), 1);
        chk("t4 ms_sel", 32'(ms_sel), 1);
        rdy = 1'b1;
        @(negedge clk);
        chk("t4 som after rdy", 32'(som), 1);
        wait_for("t4 idle", 0, 1'b0, 300);
        chk("t4 scoreboard empty", 32'(exp_q.size()), 0);

`ifdef FCOUNTER_SCHED_TIMEOUT_EN
        // ch1 never completes; sweep must time out and continue on ch2
        hang_ch = 1;
        meas_val[2] = 8'h77;
        exp_q.push_back('{2, 8'h77});
        ch_mask = 4'b0110;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_for("t5 timeout flag", 4, 1'b1, 300);
        chk("t5 ce dropped", 32'(ce), 0);
        chk("t5 ms_sel at timeout", 32'(ms_sel), 1);
        wait_for("t5 idle", 0, 1'b0, 300);
        hang_ch = -1;
        chk("t5 timeout_err", 32'(terr), 32'h2);
        chk("t5 valid ch1/ch2", 32'(valid[2:1]), 32'h2);
        chk("t5 scoreboard empty", 32'(exp_q.size()), 0);
`endif

        // reset in WAIT_HI
        meas_val[0] = 8'h33;
        ch_mask = 4'b0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_for("t6 eom low", 3, 1'b0, 300);
        @(negedge clk);
        chk("t6 ce before reset", 32'(ce), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6 busy", 32'(busy), 0);
        chk("t6 ce", 32'(ce), 0);
        chk("t6 som", 32'(som), 0);
        chk("t6 valid", 32'(valid), 0);
`ifdef FCOUNTER_SCHED_TIMEOUT_EN
        chk("t6 timeout_err", 32'(terr), 0);
`endif
        for (int a = 0; a < 4; a++) begin
            rd_addr = 2'(a);
            #1;
            chk($sformatf("t6 rd_data ch%0d", a), 32'(rd_data), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6 stays idle", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
